way_alloc_tracker: RTL and testbench

- Per-set way-state tracker for the set-associative data cache refill path.
- Holds a valid bit and a tree pseudo-LRU (PLRU) state for every set. On lookup it produces a registered allocation request vector.
- That vector drives a 2**N-to-N PriorityEncoder with N = WAY_BITS, which yields the refill way index.
- Also runs a multi-cycle flush sweep, used by fence.i / cache invalidate.

---
 rtl/cache_pkg.sv | 51 +++++
 rtl/way_alloc_tracker_plru_tree.sv | 20 ++
 rtl/way_alloc_tracker.sv | 166 ++++++++++++++++
 tb/tb_way_alloc_tracker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: flush FSM state, default geometry and tree-PLRU helpers.
// Helpers work on maximum-width vectors; callers pass the real WAY_BITS and truncate.
package cache_pkg;

    localparam int unsigned MAX_WAY_BITS  = 4;
    localparam int unsigned MAX_WAYS      = 1 << MAX_WAY_BITS;
    localparam int unsigned MAX_PLRU_BITS = MAX_WAYS - 1;
    localparam int unsigned DEF_WAY_BITS  = 2;
    localparam int unsigned DEF_WAYS      = 1 << DEF_WAY_BITS;
    localparam int unsigned DEF_SET_BITS  = 4;

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } flush_state_e;

    // Walk from the root; a 0 bit sends the walk to the left child (2i+1).
    function automatic logic [MAX_WAYS-1:0] plru_victim(input logic [MAX_PLRU_BITS-1:0] state,
                                                        input int unsigned wb);
        int node;
        int leaf;
        node = 0;
        for (int l = 0; l < int'(MAX_WAY_BITS); l++) begin
            if (l < int'(wb)) begin
                node = 2 * node + 1 + int'(state[4'(node)]);
            end
        end
        leaf = node - ((1 << wb) - 1);
        return MAX_WAYS'(1) << leaf;
    endfunction

    // Every node on the path to 'way' is pointed away from it.
    function automatic logic [MAX_PLRU_BITS-1:0] plru_update(input logic [MAX_PLRU_BITS-1:0] state,
                                                             input logic [MAX_WAY_BITS-1:0] way,
                                                             input int unsigned wb);
        logic [MAX_PLRU_BITS-1:0] s;
        int node;
        logic dir;
        s    = state;
        node = 0;
        for (int l = 0; l < int'(MAX_WAY_BITS); l++) begin
            if (l < int'(wb)) begin
                dir            = way[2'(int'(wb) - 1 - l)];
                s[4'(node)]    = ~dir;
                node           = 2 * node + 1 + int'(dir);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/way_alloc_tracker_plru_tree.sv
// Combinational tree-PLRU for one set: one-hot victim and post-touch next state.
module plru_tree
    import cache_pkg::*;
#(
    parameter int unsigned WAY_BITS = DEF_WAY_BITS
) (
    input  logic [(1 << WAY_BITS)-2:0] state_i,
    input  logic [WAY_BITS-1:0]        way_i,
    output logic [(1 << WAY_BITS)-1:0] victim_o,
    output logic [(1 << WAY_BITS)-2:0] next_o
);

    localparam int unsigned WAYS      = 1 << WAY_BITS;
    localparam int unsigned PLRU_BITS = WAYS - 1;

    assign victim_o = WAYS'(plru_victim(MAX_PLRU_BITS'(state_i), WAY_BITS));
    assign next_o   = PLRU_BITS'(plru_update(MAX_PLRU_BITS'(state_i), MAX_WAY_BITS'(way_i),
                                             WAY_BITS));

endmodule

// File: rtl/way_alloc_tracker.sv
// Per-set valid/PLRU tracker producing a registered refill allocation vector, plus flush sweep.
// Build option WAY_ALLOC_RESET_FLUSH_EN: arrays unreset, reset starts an automatic sweep.
module way_alloc_tracker
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned WAY_BITS = DEF_WAY_BITS,
    parameter int unsigned SET_BITS = $clog2(NUM_SETS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lookup_valid,
    input  logic [SET_BITS-1:0]         lookup_set,
    input  logic                        touch_valid,
    input  logic [SET_BITS-1:0]         touch_set,
    input  logic [WAY_BITS-1:0]         touch_way,
    input  logic                        touch_fill,
    input  logic                        inv_valid,
    input  logic [SET_BITS-1:0]         inv_set,
    input  logic [WAY_BITS-1:0]         inv_way,
    input  logic                        flush_req,
    output logic                        alloc_valid,
    output logic [(1 << WAY_BITS)-1:0]  free_mask,
    output logic [(1 << WAY_BITS)-1:0]  alloc_mask,
    output logic                        all_valid,
    output logic                        busy,
    output logic                        flush_done
);

    localparam int unsigned WAYS      = 1 << WAY_BITS;
    localparam int unsigned PLRU_BITS = WAYS - 1;

`ifdef WAY_ALLOC_RESET_FLUSH_EN
    localparam flush_state_e ST_RESET = StFlush;
`else
    localparam flush_state_e ST_RESET = StIdle;
`endif

    logic [WAYS-1:0]      valid_q [NUM_SETS];
    logic [WAYS-1:0]      valid_d [NUM_SETS];
    logic [PLRU_BITS-1:0] plru_q  [NUM_SETS];
    logic [PLRU_BITS-1:0] plru_d  [NUM_SETS];

    flush_state_e         state_q, state_d;
    logic [SET_BITS-1:0]  ptr_q, ptr_d;
    logic                 flush_done_q, flush_done_d;
    logic                 alloc_valid_q, alloc_valid_d;
    logic [WAYS-1:0]      free_mask_q, free_mask_d;
    logic [WAYS-1:0]      alloc_mask_q, alloc_mask_d;
    logic                 all_valid_q, all_valid_d;

    logic [WAYS-1:0]      lookup_free;
    logic [WAYS-1:0]      lookup_victim;
    logic [PLRU_BITS-1:0] lookup_next_unused;
    logic [WAYS-1:0]      touch_victim_unused;
    logic [PLRU_BITS-1:0] touch_next;

    plru_tree #(.WAY_BITS(WAY_BITS)) u_lookup_tree (
        .state_i  (plru_q[lookup_set]),
        .way_i    ('0),
        .victim_o (lookup_victim),
        .next_o   (lookup_next_unused)
    );

    plru_tree #(.WAY_BITS(WAY_BITS)) u_touch_tree (
        .state_i  (plru_q[touch_set]),
        .way_i    (touch_way),
        .victim_o (touch_victim_unused),
        .next_o   (touch_next)
    );

    // Lookup reads the pre-edge arrays, so same-cycle touch/inv are not visible.
    always_comb begin
        lookup_free   = ~valid_q[lookup_set];
        alloc_valid_d = lookup_valid;
        free_mask_d   = free_mask_q;
        alloc_mask_d  = alloc_mask_q;
        all_valid_d   = all_valid_q;
        if (lookup_valid) begin
            free_mask_d  = lookup_free;
            alloc_mask_d = (lookup_free != '0) ? lookup_free : lookup_victim;
            all_valid_d  = (lookup_free == '0);
        end
    end

    always_comb begin
        valid_d      = valid_q;
        plru_d       = plru_q;
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (touch_valid) begin
                    plru_d[touch_set] = touch_next;
                    if (touch_fill) begin
                        valid_d[touch_set][touch_way] = 1'b1;
                    end
                end
                // Applied after the fill so an invalidate of the same way wins.
                if (inv_valid) begin
                    valid_d[inv_set][inv_way] = 1'b0;
                end
                if (flush_req) begin
                    state_d = StFlush;
                    ptr_d   = '0;
                end
            end
            StFlush: begin
                valid_d[ptr_q] = '0;
                plru_d[ptr_q]  = '0;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == SET_BITS'(NUM_SETS - 1)) begin
                    state_d      = StIdle;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RESET;
            ptr_q         <= '0;
            flush_done_q  <= 1'b0;
            alloc_valid_q <= 1'b0;
            free_mask_q   <= '0;
            alloc_mask_q  <= '0;
            all_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            flush_done_q  <= flush_done_d;
            alloc_valid_q <= alloc_valid_d;
            free_mask_q   <= free_mask_d;
            alloc_mask_q  <= alloc_mask_d;
            all_valid_q   <= all_valid_d;
        end
    end

`ifdef WAY_ALLOC_RESET_FLUSH_EN
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        plru_q  <= plru_d;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end
`endif

    assign alloc_valid = alloc_valid_q;
    assign free_mask   = free_mask_q;
    assign alloc_mask  = alloc_mask_q;
    assign all_valid   = all_valid_q;
    assign busy        = (state_q == StFlush);
    assign flush_done  = flush_done_q;

endmodule

// File: tb/tb_way_alloc_tracker.sv
// Directed bench for way_alloc_tracker (NUM_SETS=16, 4 ways), hand-computed expectations.
module tb_way_alloc_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       lookup_valid;
    logic [3:0] lookup_set;
    logic       touch_valid;
    logic [3:0] touch_set;
    logic [1:0] touch_way;
    logic       touch_fill;
    logic       inv_valid;
    logic [3:0] inv_set;
    logic [1:0] inv_way;
    logic       flush_req;
    logic       alloc_valid;
    logic [3:0] free_mask;
    logic [3:0] alloc_mask;
    logic       all_valid;
    logic       busy;
    logic       flush_done;

    int checks = 0;
    int errors = 0;

    way_alloc_tracker #(.NUM_SETS(16), .WAY_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_set   (lookup_set),
        .touch_valid  (touch_valid),
        .touch_set    (touch_set),
        .touch_way    (touch_way),
        .touch_fill   (touch_fill),
        .inv_valid    (inv_valid),
        .inv_set      (inv_set),
        .inv_way      (inv_way),
        .flush_req    (flush_req),
        .alloc_valid  (alloc_valid),
        .free_mask    (free_mask),
        .alloc_mask   (alloc_mask),
        .all_valid    (all_valid),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] s);
        lookup_valid = 1'b1;
        lookup_set   = s;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic touch(input logic [3:0] s, input logic [1:0] w, input logic fill);
        touch_valid = 1'b1;
        touch_set   = s;
        touch_way   = w;
        touch_fill  = fill;
        tick();
        touch_valid = 1'b0;
        touch_fill  = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [3:0] fm, input logic [3:0] am,
                              input logic av);
        check({tag, ".alloc_valid"}, 32'(alloc_valid), 32'd1);
        check({tag, ".free_mask"},   32'(free_mask),   32'(fm));
        check({tag, ".alloc_mask"},  32'(alloc_mask),  32'(am));
        check({tag, ".all_valid"},   32'(all_valid),   32'(av));
    endtask

    // Counts cycles until flush_done, bounded; the sweep must take exactly 16.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (!flush_done && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        int   seen_done;
        logic exp_busy_rst;
`ifdef WAY_ALLOC_RESET_FLUSH_EN
        exp_busy_rst = 1'b1;
`else
        exp_busy_rst = 1'b0;
`endif
        rst = 1'b1;
        lookup_valid = 1'b0; lookup_set = '0;
        touch_valid = 1'b0; touch_set = '0; touch_way = '0; touch_fill = 1'b0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0; flush_req = 1'b0;
        #12;
        check("rst.alloc_valid", 32'(alloc_valid), 32'd0);
        check("rst.free_mask",   32'(free_mask),   32'd0);
        check("rst.alloc_mask",  32'(alloc_mask),  32'd0);
        check("rst.all_valid",   32'(all_valid),   32'd0);
        check("rst.busy",        32'(busy),        32'(exp_busy_rst));
        check("rst.flush_done",  32'(flush_done),  32'd0);
        tick();
        rst = 1'b0;
`ifdef WAY_ALLOC_RESET_FLUSH_EN
        wait_sweep("rst.sweep_len");
        tick();
`endif

        lookup(4'd3);
        check_resp("empty3", 4'b1111, 4'b1111, 1'b0);
        tick();
        check("hold.alloc_valid", 32'(alloc_valid), 32'd0);
        check("hold.free_mask",   32'(free_mask),   32'hf);

        // Set 5 filled in order 1,0,3 then 2 -> PLRU {n2=1,n1=1,root=0}, victim way1.
        touch(4'd5, 2'd1, 1'b1);
        touch(4'd5, 2'd0, 1'b1);
        touch(4'd5, 2'd3, 1'b1);
        lookup_valid = 1'b1; lookup_set = 4'd5;
        touch(4'd5, 2'd2, 1'b1);
        lookup_valid = 1'b0;
        check_resp("readold5", 4'b0100, 4'b0100, 1'b0);
        lookup(4'd5);
        check_resp("full5", 4'b0000, 4'b0010, 1'b1);

        // Set 2 filled in order 0,2,1,3 -> PLRU all zero, victim way0.
        touch(4'd2, 2'd0, 1'b1);
        touch(4'd2, 2'd2, 1'b1);
        touch(4'd2, 2'd1, 1'b1);
        touch(4'd2, 2'd3, 1'b1);
        lookup(4'd2);
        check_resp("plru2.init", 4'b0000, 4'b0001, 1'b1);
        touch(4'd2, 2'd0, 1'b0);
        lookup(4'd2);
        check_resp("plru2.t0", 4'b0000, 4'b0100, 1'b1);
        touch(4'd2, 2'd2, 1'b0);
        lookup(4'd2);
        check_resp("plru2.t2", 4'b0000, 4'b0010, 1'b1);

        // Set 7 filled 1,0,2,3 -> victim way1; then fill+inv way1 together.
        touch(4'd7, 2'd1, 1'b1);
        touch(4'd7, 2'd0, 1'b1);
        touch(4'd7, 2'd2, 1'b1);
        touch(4'd7, 2'd3, 1'b1);
        lookup(4'd7);
        check_resp("set7.full", 4'b0000, 4'b0010, 1'b1);
        inv_valid = 1'b1; inv_set = 4'd7; inv_way = 2'd1;
        touch(4'd7, 2'd1, 1'b1);
        inv_valid = 1'b0;
        lookup(4'd7);
        check_resp("set7.collide", 4'b0010, 4'b0010, 1'b0);
        touch(4'd7, 2'd1, 1'b1);
        lookup(4'd7);
        check_resp("set7.refill", 4'b0000, 4'b0100, 1'b1);
        inv_valid = 1'b1; inv_set = 4'd7; inv_way = 2'd3;
        tick();
        inv_valid = 1'b0;
        lookup(4'd7);
        check_resp("set7.inv3", 4'b1000, 4'b1000, 1'b0);

        // Full flush: touches and a repeat flush_req during the sweep are ignored.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        seen_done = 0;
        for (int k = 1; k <= 16; k++) begin
            if (busy !== 1'b1 || flush_done !== 1'b0) seen_done++;
            if (k == 10) flush_req = 1'b1;
            if (k == 14) begin
                touch_valid = 1'b1; touch_set = 4'd2; touch_way = 2'd0; touch_fill = 1'b1;
            end
            tick();
            flush_req = 1'b0;
            touch_valid = 1'b0;
            touch_fill = 1'b0;
        end
        check("flush.busy_window", 32'(seen_done), 32'd0);
        check("flush.end_busy",    32'(busy),       32'd0);
        check("flush.done_pulse",  32'(flush_done), 32'd1);
        tick();
        check("flush.done_clear",  32'(flush_done), 32'd0);
        for (int s = 0; s < 16; s++) begin
            lookup(4'(s));
            check($sformatf("flush.free%0d", s), 32'(free_mask), 32'hf);
        end

        // Reset during sweep cycle 5.
        touch(4'd12, 2'd3, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (4) tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort.busy",        32'(busy),        32'(exp_busy_rst));
        check("abort.flush_done",  32'(flush_done),  32'd0);
        check("abort.alloc_valid", 32'(alloc_valid), 32'd0);
        check("abort.free_mask",   32'(free_mask),   32'd0);
        tick();
        tick();
        rst = 1'b0;
`ifdef WAY_ALLOC_RESET_FLUSH_EN
        check("abort.restart_busy", 32'(busy), 32'd1);
        wait_sweep("abort.sweep_len");
        tick();
`else
        seen_done = 0;
        for (int k = 0; k < 24; k++) begin
            if (flush_done !== 1'b0 || busy !== 1'b0) seen_done++;
            tick();
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
`endif
        lookup(4'd12);
        check_resp("abort.set12", 4'b1111, 4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
